// File: rtl/mul8u_share_arb.sv
// mul8u_share_arb: round-robin sharing of one external 8x8 unsigned multiplier.
// Define MUL8U_ERRSTAT_EN to add err_cnt/err_sum error statistics vs the exact product.
module mul8u_share_arb #(
  parameter int NREQ  = 4,
  parameter int LAT   = 2,
  parameter int DEPTH = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*8-1:0] req_a,
  input  logic [NREQ*8-1:0] req_b,
  output logic [7:0]        mul_a,
  output logic [7:0]        mul_b,
  input  logic [15:0]       mul_o,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [15:0]       rsp_data,
  output logic [IDW-1:0]    rsp_id
`ifdef MUL8U_ERRSTAT_EN
  ,
  output logic [15:0]       err_cnt,
  output logic [23:0]       err_sum
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_FULL
  } state_e;

  state_e         state_q;
  logic [CW-1:0]  out_q;
  logic [CW-1:0]  out_d;
  logic [IDW-1:0] rr_q;
  logic [IDW-1:0] rr_d;
  logic [IDW-1:0] gnt_id;
  logic           gnt_found;
  logic           credit_ok;
  logic           accept;
  logic           pop;
  logic [IDW:0]   sum;
  logic [IDW-1:0] idx;
  logic [7:0]     sel_a;
  logic [7:0]     sel_b;
  logic [7:0]     mul_a_q;
  logic [7:0]     mul_b_q;

  logic [LAT-1:0] pv_q;
  logic [IDW-1:0] pid_q [LAT];
  logic [15:0]    wr_data;
  logic           wr_en;

  logic [15:0]    fd_q [DEPTH];
  logic [IDW-1:0] fi_q [DEPTH];
  logic [PW-1:0]  wp_q;
  logic [PW-1:0]  rp_q;
  logic [CW-1:0]  cnt_q;

`ifdef MUL8U_ERRSTAT_EN
  logic [15:0]    ex0;
  logic [15:0]    wr_ex;
  logic [15:0]    fe_q [DEPTH];
  logic [15:0]    ex_head;
  logic [15:0]    diff;
  logic [24:0]    sum_w;
  logic [15:0]    err_cnt_q;
  logic [23:0]    err_sum_q;
`endif

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Round-robin search starting at rr_q for the first valid requester
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    sum       = '0;
    idx       = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, rr_q} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(NREQ))
        sum = sum - (IDW+1)'(NREQ);
      idx = sum[IDW-1:0];
      if (!gnt_found && req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_id    = idx;
      end
    end
  end

  // No accepts while in reset or when every credit is in use
  assign credit_ok = rst_n && (state_q != S_FULL);
  assign accept    = gnt_found && credit_ok;
  assign rr_d      = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
  assign sel_a     = req_a[{gnt_id, 3'b000} +: 8];
  assign sel_b     = req_b[{gnt_id, 3'b000} +: 8];

  // One-hot ready for the granted requester
  always_comb begin
    req_ready = '0;
    if (accept)
      req_ready[gnt_id] = 1'b1;
  end

  // Operand registers hold the last accepted pair while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_a_q <= '0;
      mul_b_q <= '0;
      rr_q    <= '0;
    end else if (accept) begin
      mul_a_q <= sel_a;
      mul_b_q <= sel_b;
      rr_q    <= rr_d;
    end
  end

  assign mul_a = mul_a_q;
  assign mul_b = mul_b_q;

  // Valid/id travel alongside the product, never stalling
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv_q <= '0;
      for (int k = 0; k < LAT; k++)
        pid_q[k] <= '0;
    end else begin
      pv_q[0]  <= accept;
      pid_q[0] <= gnt_id;
      for (int k = 1; k < LAT; k++) begin
        pv_q[k]  <= pv_q[k-1];
        pid_q[k] <= pid_q[k-1];
      end
    end
  end

`ifdef MUL8U_ERRSTAT_EN
  assign ex0 = 16'(mul_a_q) * 16'(mul_b_q);
`endif

  if (LAT > 1) begin : g_pipe
    logic [15:0] pd_q [1:LAT-1];
`ifdef MUL8U_ERRSTAT_EN
    logic [15:0] pe_q [1:LAT-1];
`endif

    // Product pipeline: stage 1 samples the multiplier output
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int k = 1; k < LAT; k++) begin
          pd_q[k] <= '0;
`ifdef MUL8U_ERRSTAT_EN
          pe_q[k] <= '0;
`endif
        end
      end else begin
        pd_q[1] <= mul_o;
`ifdef MUL8U_ERRSTAT_EN
        pe_q[1] <= ex0;
`endif
        for (int k = 2; k < LAT; k++) begin
          pd_q[k] <= pd_q[k-1];
`ifdef MUL8U_ERRSTAT_EN
          pe_q[k] <= pe_q[k-1];
`endif
        end
      end
    end

    assign wr_data = pd_q[LAT-1];
`ifdef MUL8U_ERRSTAT_EN
    assign wr_ex   = pe_q[LAT-1];
`endif
  end else begin : g_direct
    assign wr_data = mul_o;
`ifdef MUL8U_ERRSTAT_EN
    assign wr_ex   = ex0;
`endif
  end

  assign wr_en     = pv_q[LAT-1];
  assign rsp_valid = (cnt_q != '0);
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_data  = fd_q[rp_q];
  assign rsp_id    = fi_q[rp_q];

  // Fall-through response FIFO; credits guarantee it is never written full
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        fd_q[k] <= '0;
        fi_q[k] <= '0;
`ifdef MUL8U_ERRSTAT_EN
        fe_q[k] <= '0;
`endif
      end
    end else begin
      if (wr_en) begin
        fd_q[wp_q] <= wr_data;
        fi_q[wp_q] <= pid_q[LAT-1];
`ifdef MUL8U_ERRSTAT_EN
        fe_q[wp_q] <= wr_ex;
`endif
        wp_q <= inc(wp_q);
      end
      if (pop)
        rp_q <= inc(rp_q);
      cnt_q <= cnt_q + CW'(wr_en) - CW'(pop);
    end
  end

  assign out_d = out_q + CW'(accept) - CW'(pop);

  // Credit FSM: outstanding = ops in pipe + ops in FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      out_q   <= '0;
    end else begin
      out_q <= out_d;
      unique case (state_q)
        S_IDLE: begin
          if (accept)
            state_q <= (out_d == CW'(DEPTH)) ? S_FULL : S_BUSY;
        end
        S_BUSY: begin
          if (out_d == '0)
            state_q <= S_IDLE;
          else if (out_d == CW'(DEPTH))
            state_q <= S_FULL;
        end
        S_FULL: begin
          if (pop)
            state_q <= (out_d == '0) ? S_IDLE : S_BUSY;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef MUL8U_ERRSTAT_EN
  assign ex_head = fe_q[rp_q];
  assign diff    = (rsp_data >= ex_head) ? rsp_data - ex_head
                                         : ex_head - rsp_data;
  assign sum_w   = {1'b0, err_sum_q} + {9'b0, diff};

  // Saturating error statistics, updated when a response is popped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
      err_sum_q <= '0;
    end else if (pop && (diff != '0)) begin
      if (err_cnt_q != 16'hFFFF)
        err_cnt_q <= err_cnt_q + 16'd1;
      err_sum_q <= sum_w[24] ? 24'hFFFFFF : sum_w[23:0];
    end
  end

  assign err_cnt = err_cnt_q;
  assign err_sum = err_sum_q;
`endif

endmodule
